vec3_normalize: RTL

//  Consumer of the vec3Length result: scales a vec3 by 1/length to produce a unit vector (ray direction).

---
 rtl/vec3_normalize.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vec3_normalize.sv
// vec3_normalize
//   Scales a signed fixed-point vec3 by 1/length to give a unit vector.
//   One shared restoring divider handles x, y and z in turn, one quotient
//   bit per cycle. Valid/ready handshake on both sides, one vector in flight.
//
//   Optional build macro: VEC3_NORM_SATURATE_EN
//     When defined, clamps each quotient magnitude to 1.0 before the sign is applied.
//     When undefined, the raw quotient is used.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   vec        {x,y,z}; each component is a signed Q(N-FRAC).FRAC value
//   length     unsigned Q(N-FRAC).FRAC magnitude of vec
//   valid_in   vec/length valid
//   ready_in   block can accept (IDLE only)
//   unit       {x,y,z} normalised result
//   valid_out  unit valid, held until ready_out
//   ready_out  downstream accepts unit
module vec3_normalize #(
  parameter int N    = 32,
  parameter int FRAC = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3*N-1:0] vec,
  input  logic [N-1:0]   length,
  input  logic           valid_in,
  output logic           ready_in,
  output logic [3*N-1:0] unit,
  output logic           valid_out,
  input  logic           ready_out
);

  localparam int K  = FRAC + 2;        // quotient bits / cycles per component
  localparam int CW = $clog2(K);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3*N-1:0] vec_q, vec_d;
  logic [3*N-1:0] unit_q, unit_d;
  logic [N-1:0]   len_q, len_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [K-1:0]   dlo_q, dlo_d;
  logic [K-1:0]   quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     comp_q, comp_d;

  logic [N:0]     rem_sh;
  logic           ge;
  logic [N-1:0]   rem_sub;
  logic [N-1:0]   ld_c;
  logic [N:0]     ld_abs;
  logic [N-1:0]   prev_c;
  logic [K-1:0]   mag;
  logic [N-1:0]   res;

  // One restoring-division step.
  // The remainder is always below len, so the N-bit subtraction cannot wrap.
  always_comb begin
    rem_sh  = {rem_q, dlo_q[K-1]};
    ge      = (rem_sh >= {1'b0, len_q});
    rem_sub = rem_sh[N-1:0] - len_q;
  end

  // Component to load into the divider.
  // In IDLE this is x from the input port.
  // In DIV it is the component after the one being finished.
  always_comb begin
    if (state_q == IDLE) begin
      ld_c = vec[3*N-1:2*N];
    end else if (comp_q == 2'd0) begin
      ld_c = vec_q[2*N-1:N];
    end else begin
      ld_c = vec_q[N-1:0];
    end
    // The value is N+1 bits wide, so -2^(N-1) has an exact magnitude.
    ld_abs = {ld_c[N-1], ld_c};
    if (ld_c[N-1]) begin
      ld_abs = -ld_abs;
    end
  end

  // A quotient is written one cycle after its last iteration.
  // By then comp_q has advanced, so the finished component is comp_q-1.
  // quo_q still holds its final value during that cycle.
  always_comb begin
    case (comp_q)
      2'd1:    prev_c = vec_q[3*N-1:2*N];
      2'd2:    prev_c = vec_q[2*N-1:N];
      default: prev_c = vec_q[N-1:0];
    endcase
    mag = quo_q;
`ifdef VEC3_NORM_SATURATE_EN
    if (quo_q > {2'b01, {FRAC{1'b0}}}) begin
      mag = {2'b01, {FRAC{1'b0}}};
    end
`endif
    res = N'(mag);
    if (prev_c[N-1]) begin
      res = -res;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unit_d  = unit_q;
    len_d   = len_q;
    rem_d   = rem_q;
    dlo_d   = dlo_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    comp_d  = comp_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          vec_d  = vec;
          len_d  = length;
          unit_d = '0;
          quo_d  = '0;
          cnt_d  = '0;
          comp_d = '0;
          if (length == '0) begin
            state_d = DONE;
          end else begin
            rem_d   = {1'b0, ld_abs[N:2]};
            dlo_d   = {ld_abs[1:0], {FRAC{1'b0}}};
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = ge ? rem_sub : rem_sh[N-1:0];
        dlo_d = {dlo_q[K-2:0], 1'b0};
        quo_d = {quo_q[K-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          case (comp_q)
            2'd1:    unit_d[3*N-1:2*N] = res;
            2'd2:    unit_d[2*N-1:N]   = res;
            2'd3:    unit_d[N-1:0]     = res;
            default: ;
          endcase
        end
        if (cnt_q == CW'(K - 1)) begin
          cnt_d  = '0;
          comp_d = comp_q + 1'b1;
          if (comp_q < 2'd2) begin
            rem_d = {1'b0, ld_abs[N:2]};
            dlo_d = {ld_abs[1:0], {FRAC{1'b0}}};
          end
        end
        // comp_q==3 is the write-back cycle for z.
        if (comp_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      unit_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      dlo_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      comp_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      unit_q  <= unit_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      dlo_q   <= dlo_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      comp_q  <= comp_d;
    end
  end

  assign ready_in  = (state_q == IDLE);
  assign valid_out = (state_q == DONE);
  assign unit      = unit_q;

endmodule
